// File: rtl/regfile_pkg.sv
// Shared constants and typedefs for the register-file operation sequencer.
package regfile_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_LDI = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } state_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_seq_ctrl_alu8.sv
// Combinational ALU for the sequencer: result and signed overflow.
// Optional macro ALU_SAT_EN clamps ADD/SUB to the signed limits on overflow.
module alu8
  import regfile_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] opX,
  input  logic [W-1:0] opY,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result,
  output logic         ovf
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  always_comb begin
    sum    = opX + opY;
    diff   = opX - opY;
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (opX[W-1] == opY[W-1]) && (sum[W-1] != opX[W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (opX[W-1] != opY[W-1]) && (diff[W-1] != opX[W-1]);
      end
      OP_AND: result = opX & opY;
      OP_OR:  result = opX | opY;
      OP_XOR: result = opX ^ opY;
      OP_SLL: result = opX << opY[2:0];
      OP_SRL: result = opX >> opY[2:0];
      OP_LDI: result = imm;
      default: result = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow sign follows X: positive X overflows upward, negative downward.
    if (ovf) result = opX[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
`endif
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Initiator-side sequencer for the 8x8 two-read/one-write register file:
// IDLE -> READ -> EXEC -> WRITE. ADD/SUB saturation selected by ALU_SAT_EN.
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic [DATA_W-1:0] req_imm,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  state_t            state, nextState;
  op_t               opQ;
  logic [ADDR_W-1:0] rdQ;
  logic [DATA_W-1:0] immQ;
  logic [DATA_W-1:0] opXQ, opYQ;
  logic [DATA_W-1:0] aluRes;
  logic              aluOvf;

  alu8 #(.W(DATA_W)) uAlu (
    .op     (opQ),
    .opX    (opXQ),
    .opY    (opYQ),
    .imm    (immQ),
    .result (aluRes),
    .ovf    (aluOvf)
  );

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (req_valid && req_ready) nextState = ST_READ;
      ST_READ:  nextState = ST_EXEC;
      ST_EXEC:  nextState = ST_WRITE;
      ST_WRITE: nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // All port outputs are registered and loaded one edge early so they are
  // stable for the whole cycle of the state that owns them.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      opQ       <= OP_ADD;
      rdQ       <= '0;
      immQ      <= '0;
      opXQ      <= '0;
      opYQ      <= '0;
      RX        <= '0;
      RY        <= '0;
      WEN       <= 1'b0;
      RW        <= '0;
      busW      <= '0;
      done      <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      req_ready <= (nextState == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            opQ  <= op_t'(req_op);
            rdQ  <= req_rd;
            immQ <= req_imm;
            RX   <= req_rs;
            RY   <= req_rt;
          end
        end
        ST_READ: begin
          opXQ <= busX;
          opYQ <= busY;
        end
        ST_EXEC: begin
          result <= aluRes;
          ovf    <= aluOvf;
          busW   <= aluRes;
          RW     <= rdQ;
          WEN    <= (rdQ != REG_ZERO);
          done   <= 1'b1;
        end
        ST_WRITE: begin
          WEN  <= 1'b0;
          done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl with a behavioural 8x8 register file.
module tb_regfile_seq_ctrl;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] req_rd, req_rs, req_rt;
  logic [7:0] req_imm;
  logic [2:0] RX, RY, RW;
  logic [7:0] busX, busY, busW;
  logic       WEN, done, ovf;
  logic [7:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef ALU_SAT_EN
  localparam logic [7:0] ADD_EXP = 8'h7F;
  localparam logic [7:0] SUBOV_EXP = 8'h80;
`else
  localparam logic [7:0] ADD_EXP = 8'h80;
  localparam logic [7:0] SUBOV_EXP = 8'h03;
`endif

  // Register file model; r0 is deliberately unguarded so any stray write shows.
  logic [7:0] rf [8] = '{default: 8'h00};
  assign busX = rf[RX];
  assign busY = rf[RY];
  always @(posedge Clk) if (WEN) rf[RW] <= busW;

  always #5 Clk = ~Clk;

  regfile_seq_ctrl dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_imm   (req_imm),
    .RX        (RX),
    .RY        (RY),
    .busX      (busX),
    .busY      (busY),
    .WEN       (WEN),
    .RW        (RW),
    .busW      (busW),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    logic [7:0] expW;
    logic       expWen;
    logic       expOvf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " WEN"},       32'(WEN),       32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " ovf"},       32'(ovf),       32'd0);
    chk({tag, " RX"},        32'(RX),        32'd0);
    chk({tag, " RY"},        32'(RY),        32'd0);
    chk({tag, " RW"},        32'(RW),        32'd0);
    chk({tag, " busW"},      32'(busW),      32'd0);
    chk({tag, " result"},    32'(result),    32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after WRITE.
  task automatic runOp(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, " ready idle"}, 32'(req_ready), 32'd1);
    req_op = v.op; req_rd = v.rd; req_rs = v.rs; req_rt = v.rt; req_imm = v.imm;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    chk({t, " ready READ"}, 32'(req_ready), 32'd0);
    chk({t, " RX"}, 32'(RX), 32'(v.rs));
    chk({t, " RY"}, 32'(RY), 32'(v.rt));
    chk({t, " WEN READ"}, 32'(WEN), 32'd0);
    chk({t, " done READ"}, 32'(done), 32'd0);
    @(negedge Clk);
    chk({t, " WEN EXEC"}, 32'(WEN), 32'd0);
    chk({t, " done EXEC"}, 32'(done), 32'd0);
    @(negedge Clk);
    chk({t, " done"}, 32'(done), 32'd1);
    chk({t, " WEN"}, 32'(WEN), 32'(v.expWen));
    chk({t, " RW"}, 32'(RW), 32'(v.rd));
    chk({t, " busW"}, 32'(busW), 32'(v.expW));
    chk({t, " result"}, 32'(result), 32'(v.expW));
    chk({t, " ovf"}, 32'(ovf), 32'(v.expOvf));
    chk({t, " ready WRITE"}, 32'(req_ready), 32'd0);
    @(negedge Clk);
    chk({t, " done clear"}, 32'(done), 32'd0);
    chk({t, " WEN clear"}, 32'(WEN), 32'd0);
    chk({t, " result hold"}, 32'(result), 32'(v.expW));
    if (v.expWen) chk({t, " rf"}, 32'(rf[v.rd]), 32'(v.expW));
  endtask

  logic [7:0] bbImm [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         acc [4];

  initial begin
    vecs[0]  = '{3'd7, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 1'b1, 1'b0};  // LDI r1,7F
    vecs[1]  = '{3'd7, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0};  // LDI r2,01
    vecs[2]  = '{3'd0, 3'd3, 3'd1, 3'd2, 8'h00, ADD_EXP, 1'b1, 1'b1};  // ADD r3,r1,r2
    vecs[3]  = '{3'd1, 3'd4, 3'd2, 3'd1, 8'h00, 8'h82, 1'b1, 1'b0};  // SUB r4,r2,r1
    vecs[4]  = '{3'd5, 3'd5, 3'd1, 3'd2, 8'h00, 8'hFE, 1'b1, 1'b0};  // SLL r5,r1,r2
    vecs[5]  = '{3'd6, 3'd5, 3'd1, 3'd2, 8'h00, 8'h3F, 1'b1, 1'b0};  // SRL r5,r1,r2
    vecs[6]  = '{3'd4, 3'd6, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0};  // XOR r6,r1,r1
    vecs[7]  = '{3'd7, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0, 1'b0};  // LDI r0,55
    vecs[8]  = '{3'd2, 3'd7, 3'd1, 3'd4, 8'h00, 8'h02, 1'b1, 1'b0};  // AND r7,r1,r4
    vecs[9]  = '{3'd3, 3'd7, 3'd2, 3'd4, 8'h00, 8'h83, 1'b1, 1'b0};  // OR r7,r2,r4
    vecs[10] = '{3'd1, 3'd6, 3'd4, 3'd1, 8'h00, SUBOV_EXP, 1'b1, 1'b1};  // SUB r6,r4,r1
    vecs[11] = '{3'd3, 3'd7, 3'd0, 3'd2, 8'h00, 8'h01, 1'b1, 1'b0};  // OR r7,r0,r2

    rst_n = 1'b0; req_valid = 1'b0;
    req_op = '0; req_rd = '0; req_rs = '0; req_rt = '0; req_imm = '0;
    repeat (2) @(negedge Clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 12; i++) runOp(vecs[i], i);
    chk("r0 stays zero", 32'(rf[0]), 32'd0);

    // Back-to-back LDI r7 requests with req_valid held high.
    begin
      int k = 0, doneIdx = 0, c = 0;
      bit pending = 0;
      req_op = 3'd7; req_rd = 3'd7; req_rs = 3'd0; req_rt = 3'd0; req_imm = bbImm[0];
      req_valid = 1'b1;
      while ((k < 4 || doneIdx < 4) && c < 40) begin
        if (pending) begin
          pending = 0;
          k++;
          if (k < 4) req_imm = bbImm[k];
          else       req_valid = 1'b0;
        end
        if (done) begin
          if (doneIdx < 4) chk($sformatf("b2b busW %0d", doneIdx), 32'(busW), 32'(bbImm[doneIdx]));
          doneIdx++;
        end
        if (req_ready && req_valid) begin
          acc[k] = c;
          pending = 1;
        end
        @(negedge Clk);
        c++;
      end
      req_valid = 1'b0;
      chk("b2b accepted", 32'(k), 32'd4);
      chk("b2b completed", 32'(doneIdx), 32'd4);
      for (int j = 1; j < 4; j++)
        chk($sformatf("b2b gap %0d", j), 32'(acc[j] - acc[j-1]), 32'd4);
      chk("b2b r7", 32'(rf[7]), 32'h44);
    end

    // Reset asserted during EXEC of ADD r3,r1,r2.
    begin
      int wenSeen = 0, doneSeen = 0;
      @(negedge Clk);
      req_op = 3'd0; req_rd = 3'd3; req_rs = 3'd1; req_rt = 3'd2; req_imm = 8'h00;
      req_valid = 1'b1;
      @(negedge Clk);
      req_valid = 1'b0;
      @(negedge Clk);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrst");
      for (int j = 0; j < 6; j++) begin
        if (j == 2) rst_n = 1'b1;
        @(negedge Clk);
        if (WEN)  wenSeen++;
        if (done) doneSeen++;
      end
      chk("midrst WEN seen", 32'(wenSeen), 32'd0);
      chk("midrst done seen", 32'(doneSeen), 32'd0);
      chk("midrst r3 kept", 32'(rf[3]), 32'(ADD_EXP));
      checkResetOutputs("postrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
